// File: rtl/lfsr_checker.sv
// Serial LFSR stream checker: fills from the line, searches for a run of
// correct predictions, then free-runs its own copy of the generator and flags
// every received bit that disagrees with it.
module lfsr_checker #(
    parameter int WIDTH       = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     taps,
    input  logic                 din,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    // Keep at least one bit even when unlock is disabled.
    localparam int EW = (UNLOCK_ERRS > 0) ? $clog2(UNLOCK_ERRS + 1) : 1;

    localparam logic [FW-1:0] FillLast   = FW'(WIDTH - 1);
    localparam logic [MW-1:0] MatchLast  = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WinLast    = WW'(WINDOW - 1);
    localparam logic [EW-1:0] UnlockLast = EW'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {StFill, StSearch, StLocked} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     c_q, c_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [MW-1:0]        match_q, match_d;
    logic [WW-1:0]        win_q, win_d;
    logic [EW-1:0]        werr_q, werr_d;
    logic                 miss;
    logic                 pred;
    logic                 locked_d, err_d;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign pred = ^(c_q & taps);

    // State, shift register and internal counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            c_q     <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
        end
    end

    // Next state: everything holds unless a bit is consumed.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        miss    = 1'b0;
        if (en) begin
            unique case (state_q)
                StFill: begin
                    c_d = {din, c_q[WIDTH-1:1]};
                    if (fill_q == FillLast) begin
                        fill_d  = '0;
                        state_d = StSearch;
                    end else begin
                        fill_d = fill_q + FW'(1);
                    end
                end
                StSearch: begin
                    c_d = {din, c_q[WIDTH-1:1]};
                    // An all-zero register predicts zero forever; never trust it.
                    if ((din == pred) && (c_q != '0)) begin
                        if (match_q == MatchLast) begin
                            match_d = '0;
                            state_d = StLocked;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                StLocked: begin
                    // Self-feed so line errors never corrupt the local generator.
                    c_d  = {pred, c_q[WIDTH-1:1]};
                    miss = (din != pred);
                    if (miss && (UNLOCK_ERRS > 0) && (werr_q == UnlockLast)) begin
                        state_d = StFill;
                        fill_d  = '0;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WinLast) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d = win_q + WW'(1);
                        if (miss) begin
                            werr_d = werr_q + EW'(1);
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    // Output next values: lock flag, error pulse, saturating error count.
    always_comb begin
        locked_d = (state_d == StLocked);
        err_d    = miss;
        cnt_d    = err_count;
        if (clr_err) begin
            cnt_d = '0;
        end else if (miss && (err_count != '1)) begin
            cnt_d = err_count + CNT_WIDTH'(1);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            locked    <= locked_d;
            err       <= err_d;
            err_count <= cnt_d;
        end
    end

endmodule
